mem_arbiter: RTL and testbench

//  Single owner of the byte-wide RAM/IO port. Arbitrates between the fetcher (4-byte instruction reads)
//  and the SLB (1/2/4-byte loads and stores) and sequences each access byte by byte.

---
 rtl/mem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM/IO port. Arbitrates fetcher vs SLB,
// then sequences each granted access one byte per cycle.
// state | meaning: IDLE arbitrate pending requests | READ byte reads in flight | WRITE byte writes in flight
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000,
  parameter logic [31:0] IO_SPAN = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetch_ce,
  input  logic [31:0] in_fetch_pc,
  output logic        out_fetch_ce,
  output logic [31:0] out_fetch_instr,
  input  logic        in_slb_ce,
  input  logic        in_slb_wr,
  input  logic [31:0] in_slb_addr,
  input  logic [2:0]  in_slb_size,
  input  logic [31:0] in_slb_data,
  output logic        out_slb_ce,
  output logic [31:0] out_slb_data,
  input  logic        in_rob_misbranch,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, len_q, len_d;
  logic        own_fetch_q, own_fetch_d, last_slb_q, last_slb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic        f_pend_q, f_pend_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        s_pend_q, s_pend_d, s_wr_q, s_wr_d;
  logic [31:0] s_addr_q, s_addr_d, s_data_q, s_data_d;
  logic [2:0]  s_size_q, s_size_d;
  logic        out_fetch_ce_q, out_fetch_ce_d, out_slb_ce_q, out_slb_ce_d;
  logic [31:0] out_fetch_instr_q, out_fetch_instr_d, out_slb_data_q, out_slb_data_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        f_new, s_new, f_go, s_go, pick_fetch;
  logic [2:0]  cnt_nx;
  logic [1:0]  rd_idx, wr_idx;

  assign out_fetch_ce    = out_fetch_ce_q;
  assign out_fetch_instr = out_fetch_instr_q;
  assign out_slb_ce      = out_slb_ce_q;
  assign out_slb_data    = out_slb_data_q;
  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = mem_wr_q;

  // Unsigned offset compare also behaves when IO_BASE+IO_SPAN would wrap.
  function automatic logic is_io(input logic [31:0] a);
    return (a - IO_BASE) < IO_SPAN;
  endfunction

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    len_d             = len_q;
    own_fetch_d       = own_fetch_q;
    last_slb_d        = last_slb_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rbuf_d            = rbuf_q;
    f_pend_d          = f_pend_q;
    f_pc_d            = f_pc_q;
    s_pend_d          = s_pend_q;
    s_wr_d            = s_wr_q;
    s_addr_d          = s_addr_q;
    s_size_d          = s_size_q;
    s_data_d          = s_data_q;
    out_fetch_ce_d    = out_fetch_ce_q;
    out_fetch_instr_d = out_fetch_instr_q;
    out_slb_ce_d      = out_slb_ce_q;
    out_slb_data_d    = out_slb_data_q;
    mem_a_d           = mem_a_q;
    mem_dout_d        = mem_dout_q;
    mem_wr_d          = mem_wr_q;
    cnt_nx            = cnt_q + 3'd1;
    rd_idx            = 2'(cnt_q - 3'd1);
    wr_idx            = cnt_nx[1:0];
    f_new             = 1'b0;
    s_new             = 1'b0;
    f_go              = 1'b0;
    s_go              = 1'b0;
    pick_fetch        = 1'b0;

    if (rdy) begin
      out_fetch_ce_d = 1'b0;
      out_slb_ce_d   = 1'b0;

      // Re-pulses while pending or in flight are dropped, as are speculative pulses under misbranch.
      f_new = in_fetch_ce && !f_pend_q && !(state_q != IDLE && own_fetch_q) && !in_rob_misbranch;
      s_new = in_slb_ce && !s_pend_q && !(state_q != IDLE && !own_fetch_q)
              && !(in_rob_misbranch && !in_slb_wr);
      if (f_new) begin
        f_pend_d = 1'b1;
        f_pc_d   = in_fetch_pc;
      end
      if (s_new) begin
        s_pend_d = 1'b1;
        s_wr_d   = in_slb_wr;
        s_addr_d = in_slb_addr;
        s_size_d = in_slb_size;
        s_data_d = in_slb_data;
      end
      if (in_rob_misbranch) begin
        f_pend_d = 1'b0;
        if (!s_wr_d) s_pend_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          f_go       = f_pend_d;
          s_go       = s_pend_d && !(s_wr_d && is_io(s_addr_d) && io_buffer_full);
          pick_fetch = f_go && (!s_go || last_slb_q);
          if (pick_fetch) begin
            f_pend_d    = 1'b0;
            own_fetch_d = 1'b1;
            last_slb_d  = 1'b0;
            addr_d      = f_pc_d;
            len_d       = 3'd4;
            cnt_d       = 3'd0;
            rbuf_d      = '0;
            mem_a_d     = f_pc_d;
            state_d     = READ;
          end else if (s_go) begin
            s_pend_d    = 1'b0;
            own_fetch_d = 1'b0;
            last_slb_d  = 1'b1;
            addr_d      = s_addr_d;
            len_d       = s_size_d;
            wdata_d     = s_data_d;
            cnt_d       = 3'd0;
            rbuf_d      = '0;
            mem_a_d     = s_addr_d;
            if (s_wr_d) begin
              mem_wr_d   = 1'b1;
              mem_dout_d = s_data_d[7:0];
              state_d    = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
        READ: begin
          if (in_rob_misbranch) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_nx;
            if (cnt_nx < len_q) mem_a_d = addr_q + 32'(cnt_nx);
            // Byte k arrives two edges after its address was issued.
            if (cnt_q != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q == len_q) begin
              state_d = IDLE;
              if (own_fetch_q) begin
                out_fetch_ce_d    = 1'b1;
                out_fetch_instr_d = rbuf_d;
              end else begin
                out_slb_ce_d   = 1'b1;
                out_slb_data_d = rbuf_d;
              end
            end
          end
        end
        WRITE: begin
          cnt_d = cnt_nx;
          if (cnt_nx < len_q) begin
            mem_a_d    = addr_q + 32'(cnt_nx);
            mem_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
          end else begin
            mem_wr_d     = 1'b0;
            out_slb_ce_d = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      len_q             <= '0;
      own_fetch_q       <= 1'b0;
      last_slb_q        <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      rbuf_q            <= '0;
      f_pend_q          <= 1'b0;
      f_pc_q            <= '0;
      s_pend_q          <= 1'b0;
      s_wr_q            <= 1'b0;
      s_addr_q          <= '0;
      s_size_q          <= '0;
      s_data_q          <= '0;
      out_fetch_ce_q    <= 1'b0;
      out_fetch_instr_q <= '0;
      out_slb_ce_q      <= 1'b0;
      out_slb_data_q    <= '0;
      mem_a_q           <= '0;
      mem_dout_q        <= '0;
      mem_wr_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      len_q             <= len_d;
      own_fetch_q       <= own_fetch_d;
      last_slb_q        <= last_slb_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      rbuf_q            <= rbuf_d;
      f_pend_q          <= f_pend_d;
      f_pc_q            <= f_pc_d;
      s_pend_q          <= s_pend_d;
      s_wr_q            <= s_wr_d;
      s_addr_q          <= s_addr_d;
      s_size_q          <= s_size_d;
      s_data_q          <= s_data_d;
      out_fetch_ce_q    <= out_fetch_ce_d;
      out_fetch_instr_q <= out_fetch_instr_d;
      out_slb_ce_q      <= out_slb_ce_d;
      out_slb_data_q    <= out_slb_data_d;
      mem_a_q           <= mem_a_d;
      mem_dout_q        <= mem_dout_d;
      mem_wr_q          <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, expected completions and writes
// queued at stimulus time and retired by a negedge monitor.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        in_fetch_ce = 1'b0;
  logic [31:0] in_fetch_pc = '0;
  logic        out_fetch_ce;
  logic [31:0] out_fetch_instr;
  logic        in_slb_ce = 1'b0;
  logic        in_slb_wr = 1'b0;
  logic [31:0] in_slb_addr = '0;
  logic [2:0]  in_slb_size = '0;
  logic [31:0] in_slb_data = '0;
  logic        out_slb_ce;
  logic [31:0] out_slb_data;
  logic        in_rob_misbranch = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_ce(in_fetch_ce), .in_fetch_pc(in_fetch_pc),
    .out_fetch_ce(out_fetch_ce), .out_fetch_instr(out_fetch_instr),
    .in_slb_ce(in_slb_ce), .in_slb_wr(in_slb_wr), .in_slb_addr(in_slb_addr),
    .in_slb_size(in_slb_size), .in_slb_data(in_slb_data),
    .out_slb_ce(out_slb_ce), .out_slb_data(out_slb_data),
    .in_rob_misbranch(in_rob_misbranch),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fetch_done = 0;
  int slb_done = 0;
  logic [31:0] exp_fetch[$];
  logic [32:0] exp_slb[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  ram [0:1023];
  logic [39:0] mon_w;
  logic [32:0] mon_s;
  logic [31:0] mon_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM returns the addressed byte one cycle after the address.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end

  always @(negedge clk) begin
    if (mem_wr) begin
      chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        mon_w = exp_wr.pop_front();
        chk("wr_addr", mem_a, mon_w[39:8]);
        chk("wr_data", 32'(mem_dout), 32'(mon_w[7:0]));
      end
    end
    if (out_fetch_ce) begin
      fetch_done++;
      chk("fetch_expected", 32'(exp_fetch.size() != 0), 32'd1);
      if (exp_fetch.size() != 0) begin
        mon_f = exp_fetch.pop_front();
        chk("fetch_instr", out_fetch_instr, mon_f);
      end
    end
    if (out_slb_ce) begin
      slb_done++;
      chk("slb_expected", 32'(exp_slb.size() != 0), 32'd1);
      if (exp_slb.size() != 0) begin
        mon_s = exp_slb.pop_front();
        if (!mon_s[32]) chk("slb_data", out_slb_data, mon_s[31:0]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic req_fetch(input logic [31:0] pc, input bit expect_done, input logic [31:0] instr);
    in_fetch_ce = 1'b1;
    in_fetch_pc = pc;
    if (expect_done) exp_fetch.push_back(instr);
  endtask

  task automatic req_slb(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] data, input bit expect_done, input int nwr,
                         input logic [31:0] exp_load);
    in_slb_ce   = 1'b1;
    in_slb_wr   = wr;
    in_slb_addr = addr;
    in_slb_size = size;
    in_slb_data = data;
    if (expect_done) exp_slb.push_back({wr, wr ? 32'h0 : exp_load});
    for (int i = 0; i < nwr; i++) exp_wr.push_back({addr + 32'(i), data[8*i +: 8]});
  endtask

  task automatic clear_req();
    in_fetch_ce = 1'b0;
    in_slb_ce   = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_fetch.size() + exp_slb.size() + exp_wr.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_fetch.size() + exp_slb.size() + exp_wr.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int snap_f, snap_s, wr_seen;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h104] = 8'h93; ram[10'h105] = 8'h02; ram[10'h106] = 8'h10; ram[10'h107] = 8'h00;
    ram[10'h200] = 8'hA5; ram[10'h201] = 8'h3C; ram[10'h202] = 8'h81; ram[10'h203] = 8'h7E;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_fetch_ce", 32'(out_fetch_ce), 32'd0);
    chk("rst_slb_ce", 32'(out_slb_ce), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_instr", out_fetch_instr, 32'h0);
    chk("rst_slb_data", out_slb_data, 32'h0);

    // Basic fetch: address walk and five-cycle latency.
    req_fetch(32'h100, 1, 32'h0000_0513);
    tick(); clear_req();
    chk("f1_a0", mem_a, 32'h100);
    chk("f1_rd", 32'(mem_wr), 32'd0);
    tick(); chk("f1_a1", mem_a, 32'h101);
    tick(); chk("f1_a2", mem_a, 32'h102);
    tick(); chk("f1_a3", mem_a, 32'h103);
    tick(); chk("f1_early", 32'(out_fetch_ce), 32'd0);
    tick(); chk("f1_done", 32'(out_fetch_ce), 32'd1);
    chk("f1_instr", out_fetch_instr, 32'h0000_0513);
    tick(); chk("f1_pulse", 32'(out_fetch_ce), 32'd0);

    // Simultaneous pair after a fetch grant: load first, then fetch.
    req_fetch(32'h100, 1, 32'h0000_0513);
    req_slb(0, 32'h200, 3'd1, 32'h0, 1, 0, 32'h0000_00A5);
    tick(); clear_req();
    chk("arb1_load_first", mem_a, 32'h200);
    tick(); tick();
    chk("arb1_load_done", 32'(out_slb_ce), 32'd1);
    tick();
    chk("arb1_fetch_next", mem_a, 32'h100);
    wait_quiet(20);

    // Lone load, then a pair: fetch wins after the SLB grant.
    req_slb(0, 32'h201, 3'd1, 32'h0, 1, 0, 32'h0000_003C);
    tick(); clear_req();
    wait_quiet(10);
    req_fetch(32'h104, 1, 32'h0010_0293);
    req_slb(0, 32'h202, 3'd2, 32'h0, 1, 0, 32'h0000_7E81);
    tick(); clear_req();
    chk("arb2_fetch_first", mem_a, 32'h104);
    wait_quiet(30);

    // 2-byte store, then read it back.
    req_slb(1, 32'h40, 3'd2, 32'h1234_BEEF, 1, 2, 32'h0);
    tick(); clear_req();
    chk("st_wr0", 32'(mem_wr), 32'd1);
    chk("st_a0", mem_a, 32'h40);
    tick();
    chk("st_wr1", 32'(mem_wr), 32'd1);
    chk("st_d1", 32'(mem_dout), 32'hBE);
    tick();
    chk("st_end_wr", 32'(mem_wr), 32'd0);
    chk("st_done", 32'(out_slb_ce), 32'd1);
    chk("st_data_hold", out_slb_data, 32'h0000_7E81);
    req_slb(0, 32'h40, 3'd2, 32'h0, 1, 0, 32'h0000_BEEF);
    tick(); clear_req();
    wait_quiet(10);

    // IO store stalled by a full buffer while a fetch completes.
    io_buffer_full = 1'b1;
    req_slb(1, 32'h0003_0000, 3'd1, 32'h0000_005A, 1, 1, 32'h0);
    req_fetch(32'h100, 1, 32'h0000_0513);
    tick(); clear_req();
    wr_seen = mem_wr ? 1 : 0;
    chk("io_fetch_granted", mem_a, 32'h100);
    repeat (5) begin
      tick();
      if (mem_wr) wr_seen++;
    end
    chk("io_stall_no_wr", 32'(wr_seen), 32'd0);
    chk("io_fetch_done", 32'(out_fetch_ce), 32'd1);
    io_buffer_full = 1'b0;
    tick();
    chk("io_store_issue", 32'(mem_wr), 32'd1);
    chk("io_store_addr", mem_a, 32'h0003_0000);
    tick();
    chk("io_store_done", 32'(out_slb_ce), 32'd1);
    wait_quiet(10);

    // Misbranch during byte 2 of a fetch; a new fetch right after.
    snap_f = fetch_done;
    req_fetch(32'h100, 0, 32'h0);
    tick(); clear_req();
    tick(); tick();
    chk("mb_a2", mem_a, 32'h102);
    in_rob_misbranch = 1'b1;
    tick();
    in_rob_misbranch = 1'b0;
    chk("mb_a_held", mem_a, 32'h102);
    req_fetch(32'h104, 1, 32'h0010_0293);
    tick(); clear_req();
    chk("mb_refetch_a", mem_a, 32'h104);
    repeat (4) tick();
    chk("mb_refetch_early", 32'(out_fetch_ce), 32'd0);
    tick();
    chk("mb_refetch_done", 32'(out_fetch_ce), 32'd1);
    chk("mb_one_done", 32'(fetch_done - snap_f), 32'd1);
    wait_quiet(10);

    // Misbranch during a 4-byte store: store completes, pending fetch discarded.
    snap_f = fetch_done;
    req_slb(1, 32'h80, 3'd4, 32'hDEAD_BEEF, 1, 4, 32'h0);
    tick(); clear_req();
    tick();
    req_fetch(32'h100, 0, 32'h0);
    tick(); clear_req();
    in_rob_misbranch = 1'b1;
    tick();
    in_rob_misbranch = 1'b0;
    chk("mbst_wr3", 32'(mem_wr), 32'd1);
    chk("mbst_a3", mem_a, 32'h83);
    tick();
    chk("mbst_done", 32'(out_slb_ce), 32'd1);
    chk("mbst_wr_end", 32'(mem_wr), 32'd0);
    repeat (8) tick();
    chk("mbst_fetch_dropped", 32'(fetch_done - snap_f), 32'd0);

    // Pending load discarded along with an in-flight fetch.
    snap_f = fetch_done;
    snap_s = slb_done;
    req_fetch(32'h104, 0, 32'h0);
    tick(); clear_req();
    req_slb(0, 32'h200, 3'd1, 32'h0, 0, 0, 32'h0);
    tick(); clear_req();
    in_rob_misbranch = 1'b1;
    tick();
    in_rob_misbranch = 1'b0;
    repeat (8) tick();
    chk("mbld_fetch_dropped", 32'(fetch_done - snap_f), 32'd0);
    chk("mbld_load_dropped", 32'(slb_done - snap_s), 32'd0);

    // Reset in the middle of a store.
    req_slb(1, 32'h90, 3'd4, 32'h0403_0201, 0, 2, 32'h0);
    tick(); clear_req();
    tick();
    chk("rstmid_wr1", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_wr_off", 32'(mem_wr), 32'd0);
    chk("rstmid_mem_a", mem_a, 32'h0);
    repeat (4) tick();

    wait_quiet(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
